// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/memory-stage arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_clt_if.sv
// rtl/mem_arb_clt_if.sv - pipeline and memory port bundle for mem_arb_clt
interface mem_arb_clt_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          flush;
    logic          dm_req;
    logic [3:0]    dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          stall_f;
    logic          stall_m;

    // Arbiter side: owns the memory request and the per-stage responses.
    modport master (
        input  if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_ready, mem_rdata, mem_rvalid,
        output if_rdata, if_valid, dm_rdata, dm_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    // Pipeline stages plus memory: the environment around the arbiter.
    modport slave (
        output if_req, if_addr, flush, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_ready, mem_rdata, mem_rvalid,
        input  if_rdata, if_valid, dm_rdata, dm_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way picker, data side first unless it won last time
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last,
    output logic   gnt_d
);

    // Data wins alone, or on a tie when fetch was the previous winner.
    assign gnt_d = req_d && (!req_i || (last != OWN_D));

endmodule

// File: rtl/mem_arb_clt.sv
// rtl/mem_arb_clt.sv - single-outstanding memory port shared by fetch and memory stage
module mem_arb_clt
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          rst_pc,
    mem_arb_clt_if.master bus
);

    state_t        state_q, state_d;
    owner_t        own_q, own_d;
    owner_t        last_q, last_d;
    logic          drop_q, drop_d;
    logic          mem_req_q, mem_req_d;
    logic [3:0]    mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic fetch_eff;
    logic gnt_d;
    logic resp_fire;
    logic kill_fetch;

    // A fetch killed this very cycle must not be granted.
    assign fetch_eff  = bus.if_req && !bus.flush;
    assign kill_fetch = bus.flush && (own_q == OWN_I);
    assign resp_fire  = (state_q == WAIT) && bus.mem_rvalid;

    rr_arb2 u_pick (
        .req_i (fetch_eff),
        .req_d (bus.dm_req),
        .last  (last_q),
        .gnt_d (gnt_d)
    );

    // State and request registers; reset aborts any transaction in flight.
    always_ff @(posedge clock or negedge rst_pc) begin
        if (!rst_pc) begin
            state_q     <= IDLE;
            own_q       <= OWN_I;
            last_q      <= OWN_I;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            last_q      <= last_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Grant in IDLE, hold the request until accepted, then wait for the response.
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        last_d      = last_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_eff || bus.dm_req) begin
                    own_d     = gnt_d ? OWN_D : OWN_I;
                    last_d    = gnt_d ? OWN_D : OWN_I;
                    mem_req_d = 1'b1;
                    state_d   = REQ;
                    if (gnt_d) begin
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end else begin
                        mem_we_d    = '0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (kill_fetch) drop_d = 1'b1;
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (kill_fetch) drop_d = 1'b1;
                if (bus.mem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // A flush arriving together with the response also suppresses it.
    assign bus.if_rdata = bus.mem_rdata;
    assign bus.dm_rdata = bus.mem_rdata;
    assign bus.if_valid = resp_fire && (own_q == OWN_I) && !drop_q && !bus.flush;
    assign bus.dm_valid = resp_fire && (own_q == OWN_D);
    assign bus.stall_f  = bus.if_req && !bus.if_valid;
    assign bus.stall_m  = bus.dm_req && !bus.dm_valid;

endmodule
